// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data load/store share one memory port.
// One transaction in flight; data has priority, bounded so a pending fetch is never starved.
module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ready,
  output logic        i_resp_valid,
  output logic [31:0] i_resp_data,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_fcn,
  input  logic [2:0]  d_req_typ,
  input  logic [31:0] d_req_wdata,
  output logic        d_req_ready,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic        d_resp_err,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic [31:0] m_req_addr,
  output logic        m_req_we,
  output logic [3:0]  m_req_be,
  output logic [31:0] m_req_wdata,
  input  logic        m_resp_valid,
  input  logic [31:0] m_resp_data
);

  // state | meaning
  // IDLE  | no transaction; arbitrate and grant (illegal data requests answered here)
  // ISSUE | m_req_valid held with stable fields until m_req_ready
  // WAIT  | request accepted; waiting for m_resp_valid
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;
  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  state_t      state;
  logic [3:0]  streak;
  logic        own_d;
  logic        cur_we;
  logic [1:0]  lo_addr;
  logic [2:0]  cur_typ;

  logic        grant_d;
  logic        grant_i;
  logic        d_legal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [15:0] lane;
  logic [31:0] load_data;

  assign grant_d = (state == IDLE) && d_req_valid && (!i_req_valid || (streak < MAX_S));
  assign grant_i = (state == IDLE) && i_req_valid && !grant_d;

  assign i_req_ready = rst_n && grant_i;
  assign d_req_ready = rst_n && grant_d;

  always_comb begin
    d_legal  = 1'b0;
    st_be    = 4'hF;
    st_wdata = d_req_wdata;
    case (d_req_typ)
      MT_B, MT_BU: begin
        d_legal  = 1'b1;
        st_be    = 4'b0001 << d_req_addr[1:0];
        st_wdata = {4{d_req_wdata[7:0]}};
      end
      MT_H, MT_HU: begin
        d_legal  = !d_req_addr[0];
        st_be    = 4'b0011 << {d_req_addr[1], 1'b0};
        st_wdata = {2{d_req_wdata[15:0]}};
      end
      MT_W:    d_legal = (d_req_addr[1:0] == 2'b00);
      default: d_legal = 1'b0;
    endcase
  end

  always_comb begin
    lane = 16'(m_resp_data >> {lo_addr, 3'b000});
    case (cur_typ)
      MT_B:    load_data = {{24{lane[7]}}, lane[7:0]};
      MT_BU:   load_data = {24'd0, lane[7:0]};
      MT_H:    load_data = {{16{lane[15]}}, lane};
      MT_HU:   load_data = {16'd0, lane};
      default: load_data = m_resp_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      streak       <= 4'd0;
      own_d        <= 1'b0;
      cur_we       <= 1'b0;
      lo_addr      <= 2'd0;
      cur_typ      <= MT_W;
      m_req_valid  <= 1'b0;
      m_req_addr   <= 32'd0;
      m_req_we     <= 1'b0;
      m_req_be     <= 4'd0;
      m_req_wdata  <= 32'd0;
      i_resp_valid <= 1'b0;
      i_resp_data  <= 32'd0;
      d_resp_valid <= 1'b0;
      d_resp_data  <= 32'd0;
      d_resp_err   <= 1'b0;
    end else begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            if (!i_req_valid)
              streak <= 4'd0;
            else if (streak < MAX_S)
              streak <= streak + 4'd1;
            if (!d_legal) begin
              // rejected without touching memory; answered on the next cycle
              d_resp_valid <= 1'b1;
              d_resp_err   <= 1'b1;
              d_resp_data  <= 32'd0;
            end else begin
              state       <= ISSUE;
              own_d       <= 1'b1;
              cur_we      <= d_req_fcn;
              lo_addr     <= d_req_addr[1:0];
              cur_typ     <= d_req_typ;
              m_req_valid <= 1'b1;
              m_req_addr  <= {d_req_addr[31:2], 2'b00};
              m_req_we    <= d_req_fcn;
              m_req_be    <= d_req_fcn ? st_be : 4'hF;
              m_req_wdata <= d_req_fcn ? st_wdata : 32'd0;
            end
          end else if (grant_i) begin
            streak      <= 4'd0;
            state       <= ISSUE;
            own_d       <= 1'b0;
            cur_we      <= 1'b0;
            lo_addr     <= i_req_addr[1:0];
            cur_typ     <= MT_W;
            m_req_valid <= 1'b1;
            m_req_addr  <= {i_req_addr[31:2], 2'b00};
            m_req_we    <= 1'b0;
            m_req_be    <= 4'hF;
            m_req_wdata <= 32'd0;
          end
        end
        ISSUE: begin
          if (m_req_ready) begin
            m_req_valid <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (m_resp_valid) begin
            state <= IDLE;
            if (own_d) begin
              d_resp_valid <= 1'b1;
              d_resp_err   <= 1'b0;
              d_resp_data  <= cur_we ? 32'd0 : load_data;
            end else begin
              i_resp_valid <= 1'b1;
              i_resp_data  <= m_resp_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic        i_req_ready;
  logic        i_resp_valid;
  logic [31:0] i_resp_data;
  logic        d_req_valid = 1'b0;
  logic [31:0] d_req_addr = '0;
  logic        d_req_fcn = 1'b0;
  logic [2:0]  d_req_typ = 3'd3;
  logic [31:0] d_req_wdata = '0;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        d_resp_err;
  logic        m_req_valid;
  logic        m_req_ready = 1'b0;
  logic [31:0] m_req_addr;
  logic        m_req_we;
  logic [3:0]  m_req_be;
  logic [31:0] m_req_wdata;
  logic        m_resp_valid = 1'b0;
  logic [31:0] m_resp_data = '0;

  mem_arbiter #(.MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_fcn(d_req_fcn),
    .d_req_typ(d_req_typ), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_we(m_req_we), .m_req_be(m_req_be), .m_req_wdata(m_req_wdata),
    .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int m_streak = 0;
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;
  string grants = "";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal_fn(input logic [2:0] typ, input logic [31:0] a);
    case (typ)
      3'd1, 3'd5: return 1'b1;
      3'd2, 3'd6: return (a % 2) == 0;
      3'd3:       return (a % 4) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] be_fn(input logic [2:0] typ, input logic [31:0] a);
    case (typ)
      3'd1, 3'd5: return 4'(1 << (a % 4));
      3'd2, 3'd6: return 4'(3 << (a & 2));
      default:    return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] wd_fn(input logic [2:0] typ, input logic [31:0] w);
    case (typ)
      3'd1, 3'd5: return (w & 32'hFF) * 32'h01010101;
      3'd2, 3'd6: return (w & 32'hFFFF) * 32'h00010001;
      default:    return w;
    endcase
  endfunction

  function automatic logic [31:0] load_fn(input logic [2:0] typ, input logic [31:0] a,
                                          input logic [31:0] w);
    logic [31:0] lane, b, h;
    lane = w >> (8 * (a % 4));
    b = lane & 32'hFF;
    h = lane & 32'hFFFF;
    case (typ)
      3'd1:    return (b ^ 32'h80) - 32'h80;
      3'd5:    return b;
      3'd2:    return (h ^ 32'h8000) - 32'h8000;
      3'd6:    return h;
      default: return w;
    endcase
  endfunction

  // One arbitration round starting with the DUT in IDLE; lat = cycles from grant to response.
  task automatic txn(input bit iv, input bit dv, input logic [31:0] ia, input logic [31:0] da,
                     input bit fcn, input logic [2:0] typ, input logic [31:0] wd,
                     input logic [31:0] mdata, input int rdly, input int wdly, input bit hold,
                     output int lat);
    bit gd, gi, legal, we;
    logic [31:0] eaddr, ewd, eresp;
    logic [3:0] ebe;
    lat = 0;
    i_req_valid = iv; i_req_addr = ia;
    d_req_valid = dv; d_req_addr = da; d_req_fcn = fcn; d_req_typ = typ; d_req_wdata = wd;
    #1;
    gd = dv && (!iv || m_streak < MAXS);
    gi = !gd && iv;
    chk("i_req_ready", i_req_ready, gi);
    chk("d_req_ready", d_req_ready, gd);
    if (gd) begin
      m_streak = iv ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      grants = {grants, "D"};
    end else if (gi) begin
      m_streak = 0;
      grants = {grants, "I"};
    end
    legal = gi || legal_fn(typ, da);
    we = gd && fcn;
    eaddr = (gi ? ia : da) & ~32'h3;
    ebe = we ? be_fn(typ, da) : 4'hF;
    ewd = we ? wd_fn(typ, wd) : 32'h0;
    tick; lat++;
    if (!hold) begin i_req_valid = 1'b0; d_req_valid = 1'b0; end
    if (!gd && !gi) begin
      chk("idle_no_mreq", m_req_valid, 0);
      chk("i_resp_hold", i_resp_data, last_i);
      chk("d_resp_hold", d_resp_data, last_d);
      return;
    end
    if (!legal) begin
      chk("illegal_no_mreq", m_req_valid, 0);
      chk("illegal_resp_valid", d_resp_valid, 1);
      chk("illegal_err", d_resp_err, 1);
      chk("illegal_data", d_resp_data, 0);
      chk("illegal_no_iresp", i_resp_valid, 0);
      last_d = 32'h0;
      return;
    end
    chk("m_req_valid", m_req_valid, 1);
    chk("m_req_addr", m_req_addr, eaddr);
    chk("m_req_we", m_req_we, we);
    chk("m_req_be", m_req_be, ebe);
    chk("m_req_wdata", m_req_wdata, ewd);
    chk("ready_low_issue", {i_req_ready, d_req_ready}, 0);
    for (int k = 0; k < rdly; k++) begin
      m_resp_valid = 1'b1;
      tick; lat++;
      m_resp_valid = 1'b0;
      chk("m_req_valid_hold", m_req_valid, 1);
      chk("m_req_addr_stable", m_req_addr, eaddr);
      chk("no_resp_issue", {i_resp_valid, d_resp_valid}, 0);
    end
    m_req_ready = 1'b1;
    tick; lat++;
    m_req_ready = 1'b0;
    chk("m_req_valid_drop", m_req_valid, 0);
    for (int k = 0; k < wdly; k++) begin
      m_req_ready = 1'b1;
      tick; lat++;
      m_req_ready = 1'b0;
      chk("no_resp_wait", {i_resp_valid, d_resp_valid}, 0);
      chk("ready_low_wait", {i_req_ready, d_req_ready}, 0);
    end
    m_resp_valid = 1'b1; m_resp_data = mdata;
    tick; lat++;
    m_resp_valid = 1'b0; m_resp_data = $urandom;
    if (gi) begin
      chk("i_resp_valid", {i_resp_valid, d_resp_valid}, 2'b10);
      chk("i_resp_data", i_resp_data, mdata);
      last_i = mdata;
    end else begin
      eresp = we ? 32'h0 : load_fn(typ, da, mdata);
      chk("d_resp_valid", {i_resp_valid, d_resp_valid}, 2'b01);
      chk("d_resp_data", d_resp_data, eresp);
      chk("d_resp_err", d_resp_err, 0);
      last_d = eresp;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mreq"}, {m_req_valid, m_req_we, m_req_be}, 0);
    chk({tag, "_maddr"}, m_req_addr, 0);
    chk({tag, "_mwdata"}, m_req_wdata, 0);
    chk({tag, "_resp_v"}, {i_resp_valid, d_resp_valid, d_resp_err}, 0);
    chk({tag, "_idata"}, i_resp_data, 0);
    chk({tag, "_ddata"}, d_resp_data, 0);
  endtask

  initial begin
    int lat;
    // reset with both requesters asking
    rst_n = 1'b0; i_req_valid = 1'b1; d_req_valid = 1'b1;
    tick; tick;
    chk("reset_ready", {i_req_ready, d_req_ready}, 0);
    chk_all_zero("reset");
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    rst_n = 1'b1;
    tick;

    // fetch word at minimum latency
    txn(1, 0, 32'h2000, 0, 0, 3, 0, 32'hDEADBEEF, 0, 0, 0, lat);
    chk("fetch_latency", lat, 3);
    chk("fetch_data_const", i_resp_data, 32'hDEADBEEF);
    tick;
    chk("fetch_pulse_one", i_resp_valid, 0);
    chk("fetch_data_hold", i_resp_data, 32'hDEADBEEF);

    // loads from word 0x80FF7F01
    txn(0, 1, 0, 32'h103, 0, 3'd1, 0, 32'h80FF7F01, 0, 0, 0, lat);
    chk("lb_const", d_resp_data, 32'hFFFFFF80);
    txn(0, 1, 0, 32'h103, 0, 3'd5, 0, 32'h80FF7F01, 1, 0, 0, lat);
    chk("lbu_const", d_resp_data, 32'h00000080);
    txn(0, 1, 0, 32'h102, 0, 3'd2, 0, 32'h80FF7F01, 0, 1, 0, lat);
    chk("lh_const", d_resp_data, 32'hFFFF80FF);
    txn(0, 1, 0, 32'h100, 0, 3'd6, 0, 32'h80FF7F01, 0, 0, 0, lat);
    chk("lhu_const", d_resp_data, 32'h00007F01);

    // stores
    txn(0, 1, 0, 32'h202, 1, 3'd1, 32'h12345678, 32'hCAFEF00D, 0, 0, 0, lat);
    txn(0, 1, 0, 32'h202, 1, 3'd2, 32'h12345678, 32'hCAFEF00D, 0, 0, 0, lat);

    // illegal data requests
    txn(0, 1, 0, 32'h301, 1, 3'd3, 32'h1, 0, 0, 0, 0, lat);
    tick;
    txn(0, 1, 0, 32'h300, 0, 3'd4, 32'h1, 0, 0, 0, 0, lat);
    tick;

    // starvation bound with both requesters held high
    rst_n = 1'b0; tick; rst_n = 1'b1; m_streak = 0; last_i = 0; last_d = 0;
    grants = "";
    for (int k = 0; k < 10; k++)
      txn(1, 1, 32'h4000 + 32'(k * 4), 32'h5000 + 32'(k * 4), 0, 3'd3, 0, $urandom, 0, 0, 1, lat);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    checks++;
    assert (grants == "DDDDIDDDDI") else begin
      failures++;
      $error("FAIL grant_order observed=%s expected=DDDDIDDDDI", grants);
    end

    // reset while waiting for a response
    i_req_valid = 1'b1; i_req_addr = 32'h6000;
    tick;
    i_req_valid = 1'b0; m_req_ready = 1'b1;
    tick;
    m_req_ready = 1'b0; rst_n = 1'b0;
    tick;
    chk_all_zero("midreset");
    rst_n = 1'b1; m_resp_valid = 1'b1; m_resp_data = 32'h11112222;
    tick;
    m_resp_valid = 1'b0;
    chk("late_resp_ignored", {i_resp_valid, d_resp_valid, m_req_valid}, 0);
    m_streak = 0; last_i = 0; last_d = 0;
    txn(1, 0, 32'h7004, 0, 0, 3, 0, 32'h0BADC0DE, 0, 0, 0, lat);
    chk("post_reset_fetch_latency", lat, 3);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      txn(1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), 3'($urandom),
          $urandom, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_D_STREAK, default 4, the maximum number of consecutive data grants while a fetch is pending (legal range 1..15).
REQ-002 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; one clock, reset synchronous and active-low.
REQ-004 SHALL have fetch ports: i_req_valid in 1; i_req_addr in 32; i_req_ready out 1; i_resp_valid out 1; i_resp_data out 32.
REQ-005 SHALL have data ports: d_req_valid in 1; d_req_addr in 32; d_req_fcn in 1 (0 = load, 1 = store); d_req_typ in 3 (MT_* encoding: B=1, H=2, W=3, BU=5, HU=6); d_req_wdata in 32; d_req_ready out 1; d_resp_valid out 1; d_resp_data out 32; d_resp_err out 1.
REQ-006 SHALL have memory ports: m_req_valid out 1; m_req_ready in 1; m_req_addr out 32 (word-aligned, bits [1:0] = 0); m_req_we out 1; m_req_be out 4; m_req_wdata out 32; m_resp_valid in 1; m_resp_data in 32.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, WAIT; there is exactly one transaction outstanding at a time.
REQ-008 In IDLE, grant: data if d_req_valid and (!i_req_valid or streak < MAX_D_STREAK); otherwise fetch if i_req_valid; otherwise none.
REQ-009 The granted requester's ready SHALL be high combinationally in IDLE only; ready is 0 in ISSUE and WAIT.
REQ-010 On grant, the block SHALL capture addr, fcn, typ and wdata; fetch is always treated as a word load.
REQ-011 Streak counter: on a data grant with i_req_valid high, increment, saturating at MAX_D_STREAK; on a fetch grant, or a data grant with i_req_valid low, clear to 0.
REQ-012 Legality: a data request is illegal if typ is not in {1,2,3,5,6}, or H/HU has addr[0]=1, or W has addr[1:0]!=0.
REQ-013 On an illegal data grant, the FSM SHALL stay in IDLE, issue no memory request, and pulse d_resp_valid=1 with d_resp_err=1 and d_resp_data=0 on the next cycle.
REQ-014 On a legal grant, the FSM SHALL go to ISSUE; in ISSUE m_req_valid=1 with stable fields until m_req_ready=1, then go to WAIT.
REQ-015 Store byte enables: B/BU give 4'b0001<<addr[1:0]; H/HU give 4'b0011<<{addr[1],1'b0}; W gives 4'hF. Loads give be=4'hF and we=0.
REQ-016 Store data replication: B gives {4{wdata[7:0]}}; H gives {2{wdata[15:0]}}; W gives wdata unchanged. Loads drive m_req_wdata=0.
REQ-017 In WAIT, on m_resp_valid=1, the owner's resp_valid SHALL be registered high for exactly one cycle and the FSM SHALL return to IDLE.
REQ-018 Load data: lane = m_resp_data >> 8*addr[1:0].
  - B: sign-extend lane[7:0].
  - BU: zero-extend lane[7:0].
  - H: sign-extend lane[15:0].
  - HU: zero-extend lane[15:0].
  - W: m_resp_data unchanged.
REQ-019 Store response: d_resp_valid pulses with d_resp_data=0 and d_resp_err=0.
REQ-020 Latency: grant in cycle N, m_req_valid from N+1; if m_req_ready at N+1 and m_resp_valid at N+2, then resp_valid is high at N+3 and a new grant is possible at N+3.
REQ-021 m_resp_valid SHALL be ignored in IDLE and ISSUE; m_req_ready SHALL be ignored outside ISSUE.
REQ-022 resp_data SHALL hold its last value while resp_valid=0; the i_ and d_ resp_valid signals are never high in the same cycle.

Reset
REQ-023 While rst_n=0 at a clock edge, the block SHALL enter IDLE and clear streak to 0.
REQ-024 While rst_n=0 at a clock edge, the block SHALL clear every output to 0: m_req_valid, m_req_we, m_req_be, m_req_addr, m_req_wdata, all resp_valid/data, and d_resp_err.
REQ-025 Ready outputs SHALL be 0 while rst_n=0.
REQ-026 Reset in ISSUE or WAIT SHALL abandon the transaction with no response; a late m_resp_valid after reset is ignored per REQ-021.

Verification
REQ-027 Fetch word: i_req addr=0x2000, m_req_ready=1 immediately, m_resp_data=0xDEADBEEF one cycle later -> m_req_addr=0x2000, be=F, we=0; i_resp_valid=1 with 0xDEADBEEF exactly 3 cycles after grant.
REQ-028 Loads from word 0x80FF7F01 at base 0x100:
  - LB at 0x103 gives 0xFFFFFF80.
  - LBU at 0x103 gives 0x00000080.
  - LH at 0x102 gives 0xFFFF80FF.
  - LHU at 0x100 gives 0x00007F01.
REQ-029 Stores:
  - SB at 0x202, wdata=0x12345678 -> m_req_be=0100, m_req_wdata=0x78787878, we=1.
  - SH at 0x202 -> be=1100, wdata=0x56785678.
  - d_resp_valid pulses with d_resp_err=0 on each.
REQ-030 Misaligned SW at 0x301 and typ=4 (D) -> no m_req_valid; d_resp_valid=1 with d_resp_err=1 on the next cycle.
REQ-031 Starvation: i_req_valid and d_req_valid held high continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-032 Reset mid-op: rst_n=0 while in WAIT, then m_resp_valid=1 after release -> no resp_valid; the next fetch request is served normally.
